muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle integer multiply/divide/multiply-accumulate engine for the EX stage.
//  Replaces the single-cycle combinational multiplier in EX, and adds DIV/DIVU and MADD/MSUB.
//  Sits beside the EX ALU. EX stalls the pipeline via stall_req_o until done_o.
//  The {hi,lo} result is written to HI/LO through the existing whilo path.
// PARAMETERS
//  WIDTH     32  operand width; results are 2*WIDTH bits as {hi,lo}
//  MUL_STEP  1   multiplier bits retired per cycle (1,2,4); must divide WIDTH
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        reset, synchronous, active-high
//  start_i        in   1        request a new operation; sampled only in IDLE
//  op_i           in   3        000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                               100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU
//  opa_i          in   WIDTH    rs operand (multiplicand / dividend)
//  opb_i          in   WIDTH    rt operand (multiplier / divisor)
//  hi_i, lo_i     in   WIDTH    forwarded HI/LO, used as accumulator base by MADD/MSUB
//  annul_i        in   1        flush: abandon the current operation
//  stall_req_o    out  1        pipeline stall request
//  done_o         out  1        one-cycle result-valid pulse
//  hi_o, lo_o     out  WIDTH    result; MUL: {hi,lo}=product, DIV: lo=quotient, hi=remainder
//  div_by_zero_o  out  1        qualifies done_o when the divisor was zero
// BEHAVIOUR
//  - Reset: state=IDLE; done_o, div_by_zero_o, hi_o, lo_o = 0; stall_req_o = 0.
//  - Operand capture: opa/opb/op/hi_i/lo_i are registered on the start edge.
//    Inputs are don't-care afterwards.
//  - States and transitions:
//    IDLE --start_i--> RUN. Exception: a DIV/DIVU with opb_i==0 goes straight to DONE.
//    RUN: iterate until the counter expires.
//      MUL: WIDTH/MUL_STEP cycles. DIV: WIDTH cycles (restoring, 1 quotient bit/cycle).
//    RUN --> FIX: 1 cycle for sign correction and, for MADD/MSUB, the 2*WIDTH add/subtract.
//    FIX --> DONE. DONE --> IDLE unconditionally.
//  - Latency (WIDTH=32, MUL_STEP=1): start in cycle 0 gives done_o=1 in cycle 34.
//    Divide by zero gives done_o in cycle 1.
//  - stall_req_o = (IDLE & start_i & ~annul_i) | RUN | FIX.
//    Combinational, so the stall is raised in the start cycle and is low in the DONE cycle.
//  - Outputs: hi_o/lo_o are registered, driven in DONE, and hold their last value otherwise.
//    div_by_zero_o is valid only while done_o=1.
//  - Signed ops: iterate on magnitudes.
//    Product and quotient are negated when the operand signs differ.
//    The remainder takes the dividend's sign.
//    Most-negative / -1: quotient = 0x80000000, remainder 0, no trap.
//  - Divide by zero: hi_o=lo_o=0, div_by_zero_o=1.
//  - MADD/MADDU: {hi,lo} = {hi_i,lo_i} + product. MSUB/MSUBU: {hi,lo} = {hi_i,lo_i} - product.
//    Both are modulo 2^(2*WIDTH) with no overflow flag.
//    MADD/MSUB use the signed product; MADDU/MSUBU use the unsigned product.
//  - Annul:
//    annul_i=1 in RUN/FIX: go to IDLE next edge; no done_o; hi_o/lo_o unchanged.
//    annul_i=1 in DONE: done_o is still asserted; EX discards it.
//    annul_i together with start_i in IDLE: the start is ignored.
//  - start_i outside IDLE is ignored; there is no queueing.
//  - Reset mid-operation: IDLE on the next edge, all outputs cleared.
// STRUCTURE
//  - Shared package muldiv_pkg: op_i encodings (MD_MULT..MD_MSUBU) and the state
//    encoding (IDLE/RUN/FIX/DONE), as 2-bit localparams.
//  - Sub-module div_core: restoring-divider step datapath (partial remainder, quotient
//    shift, iteration count). Instantiated once.
//  - Multiplier shift-add datapath, sign fix and accumulate adder stay inline.
// TESTING
//  - MULT FFFFFFFE*00000003 at cycle 0 -> cycle 34: done_o=1, hi=FFFFFFFF, lo=FFFFFFFA;
//    stall_req_o=1 in cycles 0..33.
//  - DIVU 100/7 -> lo=0000000E, hi=00000002.
//    DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//    DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  - DIV 5/0 at cycle 0 -> cycle 1: done_o=1, div_by_zero_o=1, hi=lo=0; stall low in cycle 1.
//  - MSUB hi_i=0, lo_i=0000000A, 3*5 -> hi=FFFFFFFF, lo=FFFFFFFB.
//    MADDU hi_i=0, lo_i=FFFFFFFF, 1*1 -> hi=00000001, lo=0.
//  - annul_i in cycle 10 of a MULT -> no done_o; IDLE in cycle 11.
//    New DIVU 9/3 started in cycle 11 -> lo=3, hi=0.
//  - rst in cycle 5 of a DIV -> cycle 6: IDLE, stall_req_o=0, hi_o=lo_o=0; no done_o later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide/accumulate engine.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MADD  = 3'b100;
  localparam logic [2:0] MD_MADDU = 3'b101;
  localparam logic [2:0] MD_MSUB  = 3'b110;
  localparam logic [2:0] MD_MSUBU = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_FIX  = S_FIX,
    ST_DONE = S_DONE
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_acc(input logic [2:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  // Even encodings are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    // True difference is below the divisor, so the low WIDTH bits are exact.
    trial   = shifted[WIDTH-1:0] - dvs_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = CNT_W'(WIDTH);
    end else if (step_i) begin
      rem_d = fits ? trial : shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], fits};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quot_o = quo_q;
  assign rem_o  = rem_q;
  assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle MULT/DIV/MADD/MSUB engine producing a {hi,lo} result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int unsigned MUL_CYC = WIDTH / MUL_STEP;
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
  localparam int unsigned W2      = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic [W2-1:0]    base_q, base_d;
  logic             is_div_q, is_div_d;
  logic             acc_q, acc_d;
  logic             sub_q, sub_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             div_load, div_step, div_last;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             neg_a, neg_b, start_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [W2-1:0]    partial, prod_s, result;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .quot_o     (div_quo),
    .rem_o      (div_rem),
    .last_c     (div_last)
  );

  // Operand magnitudes and final sign/accumulate fix-up.
  always_comb begin
    start_div = op_is_div(op_i);
    neg_a     = op_is_signed(op_i) & opa_i[WIDTH-1];
    neg_b     = op_is_signed(op_i) & opb_i[WIDTH-1];
    mag_a     = neg_a ? -opa_i : opa_i;
    mag_b     = neg_b ? -opb_i : opb_i;

    partial = prod_q;
    for (int i = 0; i < int'(MUL_STEP); i++) begin
      if (mplr_q[i]) partial = partial + (mcand_q << i);
    end

    prod_s = neg_res_q ? -prod_q : prod_q;
    if (is_div_q) begin
      result = {neg_rem_q ? -div_rem : div_rem, neg_res_q ? -div_quo : div_quo};
    end else if (acc_q) begin
      result = sub_q ? (base_q - prod_s) : (base_q + prod_s);
    end else begin
      result = prod_s;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    prod_d    = prod_q;
    base_d    = base_q;
    is_div_d  = is_div_q;
    acc_d     = acc_q;
    sub_d     = sub_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !annul_i) begin
          is_div_d  = start_div;
          acc_d     = op_is_acc(op_i);
          sub_d     = op_is_sub(op_i);
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          base_d    = {hi_i, lo_i};
          if (start_div && (opb_i == '0)) begin
            state_d = ST_DONE;
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
          end else begin
            state_d  = ST_RUN;
            div_load = start_div;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplr_d   = mag_b;
            prod_d   = '0;
            cnt_d    = CNT_W'(MUL_CYC);
          end
        end
      end
      ST_RUN: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else if (is_div_q) begin
          div_step = 1'b1;
          if (div_last) state_d = ST_FIX;
        end else begin
          prod_d  = partial;
          mcand_d = mcand_q << MUL_STEP;
          mplr_d  = mplr_q >> MUL_STEP;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (annul_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          hi_d    = result[W2-1:WIDTH];
          lo_d    = result[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      prod_q    <= '0;
      base_q    <= '0;
      is_div_q  <= 1'b0;
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      prod_q    <= prod_d;
      base_q    <= base_d;
      is_div_q  <= is_div_d;
      acc_q     <= acc_d;
      sub_q     <= sub_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  // Stall is raised combinationally in the start cycle so EX freezes immediately.
  assign stall_req_o   = ((state_q == ST_IDLE) && start_i && !annul_i) ||
                         (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32, MUL_STEP=1).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opa_i, opb_i, hi_i, lo_i;
  logic        annul_i;
  logic        stall_req_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .opa_i         (opa_i),
    .opb_i         (opb_i),
    .hi_i          (hi_i),
    .lo_i          (lo_i),
    .annul_i       (annul_i),
    .stall_req_o   (stall_req_o),
    .done_o        (done_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; caller is then 1 time unit into the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start op in the current cycle (cycle 0) and check latency, stall and result.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat);
    int   cyc;
    logic got;
    logic stall_ok;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = hin; lo_i = lin;
    #1;
    chk({tag, " stall_start"}, 64'(stall_req_o), 64'd1);
    cyc = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && cyc < 200) begin
      tick();
      start_i = 1'b0;
      opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
      cyc++;
      if (done_o) got = 1'b1;
      else if (!stall_req_o) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(elat));
    chk({tag, " hilo"}, {hi_o, lo_o}, {ehi, elo});
    chk({tag, " dbz"}, 64'(div_by_zero_o), 64'(edbz));
    chk({tag, " stall_done"}, 64'(stall_req_o), 64'd0);
    chk({tag, " stall_run"}, 64'(stall_ok), 64'd1);
    tick();
    chk({tag, " done_pulse"}, 64'(done_o), 64'd0);
    chk({tag, " hold"}, {hi_o, lo_o}, {ehi, elo});
  endtask

  initial begin
    logic early;
    rst = 1'b1; start_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    hi_i = '0; lo_i = '0; annul_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset state", {30'd0, done_o, div_by_zero_o, stall_req_o, hi_o, lo_o[30:0]},
        64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);

    run_op("MULT",  MD_MULT,  32'hFFFFFFFE, 32'h3, 32'h0, 32'h0,
           32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 34);
    run_op("MULTU", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    run_op("DIVU 100/7", MD_DIVU, 32'd100, 32'd7, 32'h0, 32'h0,
           32'h2, 32'hE, 1'b0, 34);
    run_op("DIV -7/2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run_op("DIV min/-1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
           32'h0, 32'h80000000, 1'b0, 34);
    run_op("DIV 5/0", MD_DIV, 32'd5, 32'd0, 32'h0, 32'h0,
           32'h0, 32'h0, 1'b1, 1);
    run_op("MSUB", MD_MSUB, 32'd3, 32'd5, 32'h0, 32'hA,
           32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 34);
    run_op("MADDU", MD_MADDU, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF,
           32'h1, 32'h0, 1'b0, 34);

    // Annul a MULT in cycle 10, then start DIVU 9/3 in cycle 11.
    start_i = 1'b1; op_i = MD_MULT; opa_i = 32'd5; opb_i = 32'd7;
    early = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      if (done_o) early = 1'b1;
    end
    annul_i = 1'b1;
    #1;
    chk("annul stall_run", 64'(stall_req_o), 64'd1);
    tick();
    annul_i = 1'b0;
    #1;
    chk("annul no_done", 64'({early, done_o}), 64'd0);
    chk("annul idle", 64'(stall_req_o), 64'd0);
    chk("annul hold", {hi_o, lo_o}, 64'h00000001_00000000);
    run_op("DIVU 9/3", MD_DIVU, 32'd9, 32'd3, 32'h0, 32'h0,
           32'h0, 32'h3, 1'b0, 34);

    // Reset in cycle 5 of a DIV.
    start_i = 1'b1; op_i = MD_DIV; opa_i = 32'd100; opb_i = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_i = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst stall", 64'(stall_req_o), 64'd0);
    chk("rst hilo", {hi_o, lo_o}, 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    early = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_o || stall_req_o) early = 1'b1;
    end
    chk("rst no_done_later", 64'(early), 64'd0);

    // start together with annul in IDLE is ignored.
    start_i = 1'b1; annul_i = 1'b1; op_i = MD_DIV; opa_i = 32'd5; opb_i = 32'd0;
    #1;
    chk("idle annul stall", 64'(stall_req_o), 64'd0);
    early = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      start_i = 1'b0; annul_i = 1'b0;
      if (done_o || stall_req_o || div_by_zero_o) early = 1'b1;
    end
    chk("idle annul ignored", 64'(early), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
